// File: rtl/demux_channel_sequencer.sv
// demux_channel_sequencer
// Drives the A/S0/S1/Enable inputs of a 1-to-4 demux. Each request goes through
// select setup, an enable pulse of DWELL_CYCLES and a gap of GAP_CYCLES, so the
// selects and data are never changed while Enable is high.
// Optional build macro DEMUX_SCAN_EN: while idle with no request pending, the
// sequencer refreshes each demux output in turn from a per-channel shadow copy.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request (or a scan slot); ReqReady high
// SETUP | one cycle; selects and data are loaded onto A/S0/S1
// DRIVE | Enable high for DWELL_CYCLES cycles; A/S0/S1 frozen
// GAP   | Enable low for GAP_CYCLES cycles; Done in first cycle only

module demux_channel_sequencer #(
    parameter int DWELL_CYCLES = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ReqValid,
    input  logic [1:0] ReqChannel,
    input  logic       ReqData,
    output logic       ReqReady,
    output logic       A,
    output logic       S0,
    output logic       S1,
    output logic       Enable,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRIVE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [1:0] lat_ch;
    logic       lat_data;
    logic       start_req;
    logic       start_scan;
    logic       scan_active;
    logic       start;

    logic       a_nxt;
    logic       s0_nxt;
    logic       s1_nxt;
    logic       en_nxt;
    logic       busy_nxt;
    logic       done_nxt;

    assign ReqReady  = (state == ST_IDLE) && !Reset;
    assign start_req = ReqReady && ReqValid;
    assign start     = start_req || start_scan;

`ifdef DEMUX_SCAN_EN
    logic [3:0] shadow;
    logic [1:0] scan_ptr;

    // A request always wins; a scan only fills otherwise idle cycles.
    assign start_scan = ReqReady && !ReqValid;

    // Shadow copy of each channel's last written data, plus round-robin scan pointer.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            shadow      <= 4'b0000;
            scan_ptr    <= 2'd0;
            scan_active <= 1'b0;
        end else begin
            if (start_req) begin
                shadow[ReqChannel] <= ReqData;
                scan_active        <= 1'b0;
            end else if (start_scan) begin
                scan_active <= 1'b1;
            end
            if (state == ST_DRIVE && cnt == 8'd0 && scan_active) begin
                scan_ptr <= scan_ptr + 2'd1;
            end
        end
    end
`else
    assign start_scan  = 1'b0;
    assign scan_active = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DRIVE and GAP leave when their down-counter reaches zero.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SETUP;
            ST_SETUP: state_next = ST_DRIVE;
            ST_DRIVE: if (cnt == 8'd0) state_next = ST_GAP;
            ST_GAP:   if (cnt == 8'd0) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Dwell/gap down-counter and the transaction latch.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt      <= 8'd0;
            lat_ch   <= 2'd0;
            lat_data <= 1'b0;
        end else begin
            case (state)
                ST_SETUP: cnt <= DWELL_LOAD;
                ST_DRIVE: cnt <= (cnt == 8'd0) ? GAP_LOAD : cnt - 8'd1;
                ST_GAP:   cnt <= (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
                default:  cnt <= 8'd0;
            endcase
            if (start_req) begin
                lat_ch   <= ReqChannel;
                lat_data <= ReqData;
            end
`ifdef DEMUX_SCAN_EN
            else if (start_scan) begin
                lat_ch   <= scan_ptr;
                lat_data <= shadow[scan_ptr];
            end
`endif
        end
    end

    // Output logic: next values of the registered demux controls.
    always_comb begin
        a_nxt    = A;
        s0_nxt   = S0;
        s1_nxt   = S1;
        en_nxt   = (state == ST_DRIVE);
        busy_nxt = (state_next != ST_IDLE);
        done_nxt = (state == ST_GAP) && (cnt == GAP_LOAD) && !scan_active;
        if (state == ST_SETUP) begin
            a_nxt  = lat_data;
            s0_nxt = lat_ch[0];
            s1_nxt = lat_ch[1];
        end
    end

    // Output registers; outputs lag the state by one cycle so selects settle before Enable.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            A      <= 1'b0;
            S0     <= 1'b0;
            S1     <= 1'b0;
            Enable <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            A      <= a_nxt;
            S0     <= s0_nxt;
            S1     <= s1_nxt;
            Enable <= en_nxt;
            Busy   <= busy_nxt;
            Done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_demux_channel_sequencer.sv
// Testbench for demux_channel_sequencer with DWELL_CYCLES=4, GAP_CYCLES=1.
module tb_demux_channel_sequencer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       ReqValid;
    logic [1:0] ReqChannel;
    logic       ReqData;
    logic       ReqReady;
    logic       A;
    logic       S0;
    logic       S1;
    logic       Enable;
    logic       Busy;
    logic       Done;

    int checks   = 0;
    int failures = 0;

    demux_channel_sequencer #(.DWELL_CYCLES(4), .GAP_CYCLES(1)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ReqValid   (ReqValid),
        .ReqChannel (ReqChannel),
        .ReqData    (ReqData),
        .ReqReady   (ReqReady),
        .A          (A),
        .S0         (S0),
        .S1         (S1),
        .Enable     (Enable),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 Clock = ~Clock;

    // {ReqReady, A, S1, S0, Enable, Busy, Done}
    typedef struct {
        logic       valid;
        logic [1:0] ch;
        logic       data;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic v, logic [1:0] c, logic d, logic [6:0] e);
        vec_t r;
        r.valid = v;
        r.ch    = c;
        r.data  = d;
        r.exp   = e;
        return r;
    endfunction

    function automatic logic [6:0] outs();
        return {ReqReady, A, S1, S0, Enable, Busy, Done};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    // Stability monitor: selects/data must not move while Enable stays high.
    logic       mon_en   = 1'b0;
    logic       prev_en  = 1'b0;
    logic [2:0] prev_sel = 3'b000;
    int         done_cnt = 0;

    always @(negedge Clock) begin
        if (mon_en) begin
            if (Done) done_cnt++;
            if (Enable && prev_en) begin
                checks++;
                if ({A, S1, S0} !== prev_sel) begin
                    failures++;
                    $display("FAIL sel_stable actual=%b expected=%b", {A, S1, S0}, prev_sel);
                end
            end
        end
        prev_en  = Enable;
        prev_sel = {A, S1, S0};
    end

    logic [1:0] t3_ch [4];
    logic       t3_d  [4];
    int         n;
    int         en_seen;
    int         done_seen;

    initial begin
        tbl[0]  = mk(1'b1, 2'd2, 1'b1, 7'b0000010);
        tbl[1]  = mk(1'b0, 2'd2, 1'b1, 7'b0110010);
        tbl[2]  = mk(1'b0, 2'd2, 1'b1, 7'b0110110);
        tbl[3]  = mk(1'b0, 2'd2, 1'b1, 7'b0110110);
        tbl[4]  = mk(1'b0, 2'd2, 1'b1, 7'b0110110);
        tbl[5]  = mk(1'b0, 2'd2, 1'b1, 7'b0110110);
        tbl[6]  = mk(1'b0, 2'd2, 1'b1, 7'b1110001);
        tbl[7]  = mk(1'b0, 2'd2, 1'b1, 7'b1110000);
        tbl[8]  = mk(1'b1, 2'd1, 1'b0, 7'b0110010);
        tbl[9]  = mk(1'b0, 2'd3, 1'b1, 7'b0001010);
        tbl[10] = mk(1'b1, 2'd3, 1'b1, 7'b0001110);
        tbl[11] = mk(1'b1, 2'd3, 1'b1, 7'b0001110);
        tbl[12] = mk(1'b1, 2'd3, 1'b1, 7'b0001110);
        tbl[13] = mk(1'b1, 2'd3, 1'b1, 7'b0001110);
        tbl[14] = mk(1'b0, 2'd3, 1'b1, 7'b1001001);
        tbl[15] = mk(1'b0, 2'd3, 1'b1, 7'b1001000);

        t3_ch[0] = 2'd0; t3_d[0] = 1'b1;
        t3_ch[1] = 2'd1; t3_d[1] = 1'b0;
        t3_ch[2] = 2'd2; t3_d[2] = 1'b1;
        t3_ch[3] = 2'd3; t3_d[3] = 1'b1;

        Reset      = 1'b1;
        ReqValid   = 1'b0;
        ReqChannel = 2'd0;
        ReqData    = 1'b0;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset_outs_%0d", i), {1'b0, outs()}, 8'h00);
        end
        Reset = 1'b0;
        #1;
        chk("ready_after_reset", {7'b0, ReqReady}, 8'h01);

        // 20 idle cycles: nothing should move.
        en_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Enable) en_seen++;
        end
        chk("idle_outs", {1'b0, outs()}, 8'h40);
        chk("idle_enable_count", 8'(en_seen), 8'd0);

        // Table: ch2/data1 transaction, then ch1/data0 with inputs wiggled during DRIVE.
        for (int i = 0; i < 16; i++) begin
            ReqValid   = tbl[i].valid;
            ReqChannel = tbl[i].ch;
            ReqData    = tbl[i].data;
            tick();
            chk($sformatf("vec_%0d", i), {1'b0, outs()}, {1'b0, tbl[i].exp});
        end
        ReqValid = 1'b0;
        tick();

        // ReqValid held high across four back-to-back requests.
        done_cnt = 0;
        mon_en   = 1'b1;
        ReqValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ReqChannel = t3_ch[i];
            ReqData    = t3_d[i];
            n = 0;
            while (!ReqReady && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("t3_ready_%0d", i), {7'b0, ReqReady}, 8'h01);
            tick();
            if (i == 3) ReqValid = 1'b0;
            ReqChannel = ~t3_ch[i];
            ReqData    = ~t3_d[i];
            tick();
            chk($sformatf("t3_sel_%0d", i), {5'b0, A, S1, S0}, {5'b0, t3_d[i], t3_ch[i]});
        end
        n = 0;
        while (!ReqReady && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        mon_en = 1'b0;
        chk("t3_ready_end", {7'b0, ReqReady}, 8'h01);
        chk("t3_done_count", 8'(done_cnt), 8'd4);

        // Reset in the second DRIVE cycle drops the transaction.
        ReqValid   = 1'b1;
        ReqChannel = 2'd3;
        ReqData    = 1'b1;
        tick();
        ReqValid = 1'b0;
        tick();
        tick();
        chk("t5_enable_before_reset", {7'b0, Enable}, 8'h01);
        Reset = 1'b1;
        tick();
        chk("t5_outs_in_reset", {1'b0, outs()}, 8'h00);
        Reset = 1'b0;
        tick();
        chk("t5_outs_after_reset", {1'b0, outs()}, 8'h40);

        // Fresh request after the reset completes normally.
        ReqValid   = 1'b1;
        ReqChannel = 2'd0;
        ReqData    = 1'b1;
        tick();
        ReqValid = 1'b0;
        tick();
        chk("t5_fresh_sel", {5'b0, A, S1, S0}, 8'b00000100);
        done_seen = 0;
        n = 0;
        while (done_seen == 0 && n < 12) begin
            tick();
            if (Done) done_seen = 1;
            n++;
        end
        chk("t5_fresh_done", 8'(done_seen), 8'd1);
        chk("t5_fresh_ready", {7'b0, ReqReady}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
